serial_tx_parity: RTL and testbench

SERIAL_TX_PARITY -- requirements
Module: serial_tx_parity

---
 rtl/serial_tx_parity.sv | 150 +++++++++++++++
 tb/tb_serial_tx_parity.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_parity.sv
// Serial byte transmitter: start bit, 8 data bits LSB first, parity bit, stop bit.
// Back-to-back bytes are accepted in the last stop cycle with no idle gap.
//
// state  | meaning
// IDLE   | line held at 1, ready for a byte
// START  | driving the start bit (0)
// DATA   | shifting out data bits 0..7
// PARITY | driving the precomputed parity bit
// STOP   | driving the stop bit (1); last cycle may accept the next byte
module serial_tx_parity #(
    parameter int CLKS_PER_BIT = 1,
    parameter bit ODD_PARITY   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_data,
    output logic       o_busy,
    output logic       o_done
);

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic last_bit;
    logic accept;
    logic cap_parity;

    assign last_bit   = (cnt_q == CNT_LAST);
    assign o_ready    = (state_q == IDLE) || ((state_q == STOP) && last_bit);
    assign accept     = i_valid && o_ready;
    assign cap_parity = ODD_PARITY ? ~(^i_byte) : (^i_byte);

    assign o_data = data_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = last_bit ? '0 : cnt_q + CNT_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        data_d    = data_q;

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                data_d    = 1'b1;
                if (accept) begin
                    state_d  = START;
                    shift_d  = i_byte;
                    parity_d = cap_parity;
                    data_d   = 1'b0;
                end
            end
            START: begin
                if (last_bit) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    data_d    = shift_q[0];
                end
            end
            DATA: begin
                if (last_bit) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY;
                        data_d  = parity_q;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        data_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (last_bit) begin
                    state_d = STOP;
                    data_d  = 1'b1;
                end
            end
            STOP: begin
                if (last_bit) begin
                    if (accept) begin
                        state_d  = START;
                        shift_d  = i_byte;
                        parity_d = cap_parity;
                        data_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        data_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                data_d    = 1'b1;
            end
        endcase

        // Outputs are registered, so derive them from where the FSM is going next.
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            data_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_parity.sv
// Bench for serial_tx_parity: one DUT at 1 clk/bit odd parity, one at 4 clk/bit even parity.
// A per-DUT scoreboard queues expected line/busy/done/ready per cycle at each acceptance.
module tb_serial_tx_parity;

    logic       clk;
    logic       rst_n;
    logic       va, vb;
    logic [7:0] i_byte;
    logic       a_ready, a_data, a_busy, a_done;
    logic       b_ready, b_data, b_busy, b_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [3:0] qa[$];
    logic [3:0] qb[$];

    int done_a = 0, done_b = 0;
    int run_a = 0, run_b = 0, last_run_a = 0, last_run_b = 0;
    int last_done_a = 0, prev_done_a = 0;

    serial_tx_parity #(.CLKS_PER_BIT(1), .ODD_PARITY(1'b1)) u_dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (va),
        .i_byte  (i_byte),
        .o_ready (a_ready),
        .o_data  (a_data),
        .o_busy  (a_busy),
        .o_done  (a_done)
    );

    serial_tx_parity #(.CLKS_PER_BIT(4), .ODD_PARITY(1'b0)) u_dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (vb),
        .i_byte  (i_byte),
        .o_ready (b_ready),
        .o_data  (b_data),
        .o_busy  (b_busy),
        .o_done  (b_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {data, busy, done, ready} for cycle k of a frame.
    function automatic logic [3:0] exp_entry(input logic [7:0] b, input int cpb,
                                             input bit odd, input int k);
        int   bi;
        int   ones;
        logic par;
        logic d;
        logic last;
        bi   = k / cpb;
        ones = $countones(b);
        par  = odd ? ((ones % 2) == 0) : ((ones % 2) == 1);
        if (bi == 0)      d = 1'b0;
        else if (bi <= 8) d = b[bi-1];
        else if (bi == 9) d = par;
        else              d = 1'b1;
        last = (k == 11 * cpb - 1);
        return {d, 1'b1, last, last};
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && va && a_ready)
            for (int k = 0; k < 11; k++) qa.push_back(exp_entry(i_byte, 1, 1'b1, k));
        if (rst_n && vb && b_ready)
            for (int k = 0; k < 44; k++) qb.push_back(exp_entry(i_byte, 4, 1'b0, k));
    end

    always @(negedge clk) begin
        logic [3:0] e;
        e = (qa.size() > 0) ? qa.pop_front() : 4'b1001;
        total++;
        if ({a_data, a_busy, a_done, a_ready} !== e) begin
            bad++;
            $display("FAIL sb_a cyc=%0d got=%b exp=%b (data,busy,done,ready)",
                     cyc, {a_data, a_busy, a_done, a_ready}, e);
        end
        if (a_done) begin
            done_a++;
            prev_done_a = last_done_a;
            last_done_a = cyc;
        end
        if (a_busy) run_a++;
        else begin
            if (run_a != 0) last_run_a = run_a;
            run_a = 0;
        end
    end

    always @(negedge clk) begin
        logic [3:0] e;
        e = (qb.size() > 0) ? qb.pop_front() : 4'b1001;
        total++;
        if ({b_data, b_busy, b_done, b_ready} !== e) begin
            bad++;
            $display("FAIL sb_b cyc=%0d got=%b exp=%b (data,busy,done,ready)",
                     cyc, {b_data, b_busy, b_done, b_ready}, e);
        end
        if (b_done) done_b++;
        if (b_busy) run_b++;
        else begin
            if (run_b != 0) last_run_b = run_b;
            run_b = 0;
        end
    end

    function automatic logic rdy(input int d);
        return (d == 0) ? a_ready : b_ready;
    endfunction

    task automatic send(input int d, input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        #1;
        i_byte = b;
        if (d == 0) va = 1'b1; else vb = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(posedge clk);
            if (rdy(d)) ok = 1'b1;
        end
        #1;
        if (d == 0) va = 1'b0; else vb = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL accept_timeout dut=%0d byte=%h got=no_accept exp=accept", d, b);
        end
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 400 && !ok; n++) begin
            @(negedge clk);
            if (((d == 0) ? a_busy : b_busy) == 1'b0) ok = 1'b1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL idle_timeout dut=%0d got=busy exp=idle", d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({a_data, a_busy, a_done, a_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL reset_a got=%b exp=1001", {a_data, a_busy, a_done, a_ready});
        end
        total++;
        if ({b_data, b_busy, b_done, b_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL reset_b got=%b exp=1001", {b_data, b_busy, b_done, b_ready});
        end
    endtask

    // First acceptance on the first edge after release, then the 0xA5 frame bit by bit.
    task automatic test_first_frame_a5();
        logic [10:0] seq;
        seq = 11'b111_0100_1010;
        @(negedge clk);
        #1;
        i_byte = 8'hA5;
        va     = 1'b1;
        rst_n  = 1'b1;
        @(posedge clk);
        total++;
        if (a_ready !== 1'b1) begin
            bad++;
            $display("FAIL first_accept got=%b exp=1", a_ready);
        end
        #1;
        va = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            total++;
            if (a_data !== seq[c-1] || a_done !== (c == 11)) begin
                bad++;
                $display("FAIL a5_cycle%0d got data=%b done=%b exp data=%b done=%b",
                         c, a_data, a_done, seq[c-1], (c == 11));
            end
        end
    endtask

    task automatic send_parity(input int d, input logic [7:0] b, input logic exp_par);
        int cpb;
        cpb = (d == 0) ? 1 : 4;
        send(d, b);
        repeat (9 * cpb + 1) @(negedge clk);
        total++;
        if (((d == 0) ? a_data : b_data) !== exp_par) begin
            bad++;
            $display("FAIL parity dut=%0d byte=%h got=%b exp=%b",
                     d, b, (d == 0) ? a_data : b_data, exp_par);
        end
        wait_idle(d);
    endtask

    task automatic test_parity();
        send_parity(0, 8'h00, 1'b1);
        send_parity(0, 8'hFF, 1'b1);
        send_parity(0, 8'h01, 1'b0);
        send_parity(1, 8'h01, 1'b1);
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_a;
        send(0, 8'h3C);
        send(0, 8'hC3);
        wait_idle(0);
        total++;
        if (last_run_a != 22) begin
            bad++;
            $display("FAIL b2b_busy_run got=%0d exp=22", last_run_a);
        end
        total++;
        if (done_a - d0 != 2 || last_done_a - prev_done_a != 11) begin
            bad++;
            $display("FAIL b2b_done got pulses=%0d gap=%0d exp pulses=2 gap=11",
                     done_a - d0, last_done_a - prev_done_a);
        end
    endtask

    task automatic test_clks4();
        int d0;
        d0 = done_b;
        send(1, 8'h81);
        wait_idle(1);
        total++;
        if (last_run_b != 44) begin
            bad++;
            $display("FAIL clks4_busy_run got=%0d exp=44", last_run_b);
        end
        total++;
        if (done_b - d0 != 1) begin
            bad++;
            $display("FAIL clks4_done got=%0d exp=1", done_b - d0);
        end
    endtask

    task automatic test_reset_abort();
        int d0;
        d0 = done_a;
        send(0, 8'h5A);
        repeat (5) @(negedge clk);
        #1;
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        total++;
        if (a_data !== 1'b1 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_immediate got data=%b busy=%b exp data=1 busy=0", a_data, a_busy);
        end
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if (done_a != d0) begin
            bad++;
            $display("FAIL abort_no_done got=%0d exp=0", done_a - d0);
        end
        send(0, 8'h12);
        wait_idle(0);
        total++;
        if (done_a - d0 != 1) begin
            bad++;
            $display("FAIL after_abort_done got=%0d exp=1", done_a - d0);
        end
    endtask

    task automatic test_ignore_while_busy();
        int d0;
        d0 = done_a;
        send(0, 8'h96);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            va     = 1'b1;
            i_byte = 8'($urandom_range(0, 255));
            @(posedge clk);
            total++;
            if (a_ready !== 1'b0) begin
                bad++;
                $display("FAIL ignore_ready k=%0d got=%b exp=0", k, a_ready);
            end
            #1;
            va = 1'b0;
        end
        wait_idle(0);
        repeat (3) @(negedge clk);
        total++;
        if (a_busy !== 1'b0 || done_a - d0 != 1) begin
            bad++;
            $display("FAIL ignore_extra_frame got busy=%b done=%0d exp busy=0 done=1",
                     a_busy, done_a - d0);
        end
    endtask

    initial begin
        va     = 1'b0;
        vb     = 1'b0;
        i_byte = 8'h00;
        rst_n  = 1'b1;
        #1;
        rst_n = 1'b0;
        test_reset();
        test_first_frame_a5();
        test_parity();
        test_back_to_back();
        test_clks4();
        test_reset_abort();
        test_ignore_while_busy();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule
